braun_mult_arbiter: RTL and testbench

//  - Shares one combinational braun_multiplier instance among NUM_REQ requesters.
//  - Arbitration is round-robin. Requests use a valid/ready handshake.
//  - The product is registered and returned on a single response channel, tagged

---
 rtl/braun_mult_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_braun_mult_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/braun_mult_arbiter.sv
// braun_mult_arbiter
//   Round-robin front end that lets NUM_REQ requesters share one combinational
//   Braun array multiplier. The winning requester's operands are latched on
//   accept, multiplied, and the registered product is returned on a single
//   valid/ready response channel tagged with the requester index.
//
//   Optional build macro: MULT_PIPE_EN adds a MUL2 state and a second product
//   register stage (response latency T+3 instead of T+2).
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester operand-pending flags
//   req_a/b    packed operands, requester i owns slice [i*WIDTH +: WIDTH]
//   req_ready  one-hot (or zero) accept strobe, only ever high in IDLE
//   rsp_valid  product available, held until rsp_ready
//   rsp_ready  consumer accepts the product
//   rsp_p      full 2*WIDTH unsigned product
//   rsp_id     index of the requester that issued the operands
//   busy       high whenever the FSM is not IDLE

// Unsigned Braun array multiplier: carry-save rows of full adders followed by
// a ripple carry adder for the upper half. Purely combinational.
module braun_multiplier #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);
    // Row r holds sum bits at weight r+j and carry bits at weight r+j+1.
    logic [WIDTH*WIDTH-1:0] s_flat;
    logic [WIDTH*WIDTH-1:0] c_flat;
    logic [WIDTH-1:0]       rc;

    genvar gi, gj;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_row
            for (gj = 0; gj < WIDTH; gj++) begin : g_col
                if (gi == 0) begin : g_first
                    assign s_flat[gj] = a[gj] & b[0];
                    assign c_flat[gj] = 1'b0;
                end else begin : g_fa
                    logic fa_x;
                    logic fa_y;
                    logic fa_z;
                    assign fa_x = a[gj] & b[gi];
                    if (gj < WIDTH - 1) begin : g_in
                        assign fa_y = s_flat[(gi-1)*WIDTH + gj + 1];
                    end else begin : g_edge
                        assign fa_y = 1'b0;
                    end
                    assign fa_z = c_flat[(gi-1)*WIDTH + gj];
                    assign s_flat[gi*WIDTH + gj] = fa_x ^ fa_y ^ fa_z;
                    assign c_flat[gi*WIDTH + gj] = (fa_x & fa_y) | (fa_x & fa_z) | (fa_y & fa_z);
                end
            end
            // Lowest sum bit of each row is a finished product bit.
            assign p[gi] = s_flat[gi*WIDTH];
        end

        // Merge the last row's sum and carry vectors into the upper half.
        // The product fits in 2*WIDTH bits, so the final carry-out is always 0.
        for (gi = 0; gi < WIDTH; gi++) begin : g_cpa
            logic cpa_s;
            logic cpa_c;
            if (gi < WIDTH - 1) begin : g_sum
                assign cpa_s = s_flat[(WIDTH-1)*WIDTH + gi + 1];
            end else begin : g_nosum
                assign cpa_s = 1'b0;
            end
            assign cpa_c = c_flat[(WIDTH-1)*WIDTH + gi];
            if (gi == 0) begin : g_cin
                assign rc[0] = 1'b0;
            end
            assign p[WIDTH + gi] = cpa_s ^ cpa_c ^ rc[gi];
            if (gi < WIDTH - 1) begin : g_carry
                assign rc[gi+1] = (cpa_s & cpa_c) | (cpa_s & rc[gi]) | (cpa_c & rc[gi]);
            end
        end
    endgenerate
endmodule

module braun_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 2,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_p,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_MUL2, ST_RESP} state_t;

    state_t             state_reg, state_next;
    logic [ID_W-1:0]    ptr_reg;
    logic [WIDTH-1:0]   op_a_reg, op_b_reg;
    logic [ID_W-1:0]    op_id_reg;
    logic [2*WIDTH-1:0] res_p_reg;
    logic [2*WIDTH-1:0] mult_p;

    logic [WIDTH-1:0]   a_arr [NUM_REQ];
    logic [WIDTH-1:0]   b_arr [NUM_REQ];
    logic [NUM_REQ-1:0] above_ptr;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic               accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_arr[gi]     = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]     = req_b[gi*WIDTH +: WIDTH];
            assign above_ptr[gi] = req_valid[gi] && (ID_W'(gi) > ptr_reg);
        end
    endgenerate

    // Round-robin: lowest valid index above ptr wins; if none, wrap around to
    // the lowest valid index overall (which includes ptr itself last).
    always_comb begin
        grant_idx   = '0;
        grant_found = |req_valid;
        if (|above_ptr) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (above_ptr[i]) grant_idx = ID_W'(i);
            end
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_valid[i]) grant_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a = a_arr[i];
                sel_b = b_arr[i];
            end
        end
    end

    assign accept = (state_reg == ST_IDLE) && grant_found;

    braun_multiplier #(.WIDTH(WIDTH)) u_mult (
        .a (op_a_reg),
        .b (op_b_reg),
        .p (mult_p)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (grant_found) state_next = ST_MUL;
`ifdef MULT_PIPE_EN
            ST_MUL:  state_next = ST_MUL2;
            ST_MUL2: state_next = ST_RESP;
`else
            ST_MUL:  state_next = ST_RESP;
`endif
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = (state_reg != ST_IDLE);
        if (accept)                req_ready = NUM_REQ'(1) << grant_idx;
        if (state_reg == ST_RESP)  rsp_valid = 1'b1;
    end

`ifdef MULT_PIPE_EN
    logic [2*WIDTH-1:0] out_p_reg;
`endif

    // Datapath registers; operands are only sampled in the accept cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg   <= ID_W'(NUM_REQ - 1);
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            op_id_reg <= '0;
            res_p_reg <= '0;
`ifdef MULT_PIPE_EN
            out_p_reg <= '0;
`endif
        end else begin
            if (accept) begin
                op_a_reg  <= sel_a;
                op_b_reg  <= sel_b;
                op_id_reg <= grant_idx;
                ptr_reg   <= grant_idx;
            end
            if (state_reg == ST_MUL) res_p_reg <= mult_p;
`ifdef MULT_PIPE_EN
            if (state_reg == ST_MUL2) out_p_reg <= res_p_reg;
`endif
        end
    end

`ifdef MULT_PIPE_EN
    assign rsp_p = out_p_reg;
`else
    assign rsp_p = res_p_reg;
`endif
    assign rsp_id = op_id_reg;
endmodule

// File: tb/tb_braun_mult_arbiter.sv
// Self-checking bench for braun_mult_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (round-robin pick, latency countdown, held response).
module tb_braun_mult_arbiter;
    localparam int N = 4;
    localparam int W = 2;
    localparam int IDW = 2;
`ifdef MULT_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2*W-1:0]   rsp_p;
    logic [IDW-1:0]   rsp_id;
    logic             busy;

    logic [W-1:0]     op_a [N];
    logic [W-1:0]     op_b [N];

    int n_vec  = 0;
    int n_miss = 0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign req_a[gi*W +: W] = op_a[gi];
            assign req_b[gi*W +: W] = op_b[gi];
        end
    endgenerate

    braun_mult_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode 0 = idle, 1 = computing (cnt cycles left), 2 = response pending
    int m_ptr  = N - 1;
    int m_mode = 0;
    int m_cnt  = 0;
    int m_p    = 0;
    int m_id   = 0;
    bit chk_en = 1'b0;
    logic [N-1:0] acc_mask = '0;
    int log_id [$];
    int log_p  [$];

    function automatic int rr_winner(input int p, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ptr = N - 1; m_mode = 0; m_cnt = 0; chk_en = 1'b1;
        end else if (chk_en) begin
            case (m_mode)
                0: begin
                    int w;
                    w = rr_winner(m_ptr, req_valid);
                    if (w >= 0) begin
                        m_p = int'(op_a[w]) * int'(op_b[w]);
                        m_id = w; m_ptr = w; m_cnt = LAT - 1; m_mode = 1;
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_mode = 2;
                end
                default: if (rsp_ready) m_mode = 0;
            endcase
        end
    end

    // Compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            int w;
            logic [N-1:0] er;
            er = '0;
            if (m_mode == 0) begin
                w = rr_winner(m_ptr, req_valid);
                if (w >= 0) er[w] = 1'b1;
            end
            check("req_ready", int'(req_ready), int'(er));
            check("busy", int'(busy), int'(m_mode != 0));
            check("rsp_valid", int'(rsp_valid), int'(m_mode == 2));
            if (m_mode == 2) begin
                check("rsp_p", int'(rsp_p), m_p);
                check("rsp_id", int'(rsp_id), m_id);
            end
            acc_mask = req_valid & req_ready;
            if (rsp_valid && rsp_ready) begin
                log_id.push_back(int'(rsp_id));
                log_p.push_back(int'(rsp_p));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance to just after the next rising edge; requesters that were
    // accepted in the cycle that just ended drop their valid.
    task automatic tick();
        logic r;
        @(posedge clk);
        r = rst;
        #1;
        if (!r) req_valid = req_valid & ~acc_mask;
    endtask

    task automatic wait_log(input int n, input int budget);
        int c;
        c = 0;
        while (log_id.size() < n && c < budget) begin
            tick();
            c++;
        end
        if (log_id.size() < n) check("timeout_wait_rsp", log_id.size(), n);
    endtask

    task automatic set_req(input int i, input int a, input int b);
        op_a[i] = W'(a);
        op_b[i] = W'(b);
        req_valid[i] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rsp_p", int'(rsp_p), 0);
        check("rst_rsp_id", int'(rsp_id), 0);
        check("rst_req_ready", int'(req_ready), 0);

        // Scenario 1: single op 3*3 from requester 0
        tick();
        set_req(0, 3, 3);
        @(negedge clk);
        check("s1_grant", int'(req_ready), 1);
        repeat (LAT - 1) tick();
        @(negedge clk);
        check("s1_not_early", int'(rsp_valid), 0);
        tick();
        @(negedge clk);
        check("s1_valid", int'(rsp_valid), 1);
        check("s1_p", int'(rsp_p), 9);
        check("s1_id", int'(rsp_id), 0);
        tick();
        @(negedge clk);
        check("s1_busy_done", int'(busy), 0);

        // Scenario 2: all requesters valid from reset, a=i, b=3
        tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, i, 3);
        log_id.delete(); log_p.delete();
        repeat (2) tick();
        rst = 1'b0;
        wait_log(4, 80);
        for (int k = 0; k < 4 && k < log_id.size(); k++) begin
            check("s2_order_id", log_id[k], k);
            check("s2_product", log_p[k], 3 * k);
        end

        // Scenario 3: back-pressure for 5 cycles, with another requester waiting
        log_id.delete(); log_p.delete();
        rsp_ready = 1'b0;
        set_req(1, 2, 3);
        set_req(2, 1, 1);
        begin
            int c;
            c = 0;
            @(negedge clk);
            while (!rsp_valid && c < 20) begin tick(); @(negedge clk); c++; end
            check("s3_reached_resp", int'(rsp_valid), 1);
        end
        repeat (5) begin
            check("s3_hold_valid", int'(rsp_valid), 1);
            check("s3_hold_p", int'(rsp_p), 6);
            check("s3_hold_id", int'(rsp_id), 1);
            check("s3_no_grant", int'(req_ready), 0);
            tick();
            @(negedge clk);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("s3_release_valid", int'(rsp_valid), 1);
        tick();
        @(negedge clk);
        check("s3_done_count", log_id.size(), 1);
        check("s3_done_valid", int'(rsp_valid), 0);
        wait_log(2, 40);

        // Scenario 4: all 16 operand pairs on a rotating requester
        log_id.delete(); log_p.delete();
        for (int k = 0; k < 16; k++) begin
            set_req(k % N, k / 4, k % 4);
            wait_log(k + 1, 40);
            if (log_id.size() > k) begin
                check("s4_product", log_p[k], (k / 4) * (k % 4));
                check("s4_id", log_id[k], k % N);
            end
        end

        // Scenario 5: reset while in MUL
        log_id.delete(); log_p.delete();
        set_req(2, 3, 2);
        @(negedge clk);
        check("s5_grant2", int'(req_ready), 4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("s5_rsp_valid", int'(rsp_valid), 0);
        check("s5_busy", int'(busy), 0);
        check("s5_rsp_p", int'(rsp_p), 0);
        check("s5_rsp_id", int'(rsp_id), 0);
        check("s5_req_ready", int'(req_ready), 0);
        repeat (6) tick();
        check("s5_no_response", log_id.size(), 0);
        set_req(0, 1, 2);
        set_req(3, 2, 2);
        @(negedge clk);
        check("s5_req0_first", int'(req_ready), 1);
        wait_log(2, 40);

        // Randomized traffic with back-pressure and occasional resets
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 249) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
        end
        tick();
        rst = 1'b0; rsp_ready = 1'b1; req_valid = '0;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
